// File: rtl/acc_drain.sv
// Collects per-column accumulator results from the systolic-array controller into an
// N x N tile buffer, then streams the tile out row-major over a valid/ready port.
module acc_drain #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int LOG_N = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [N-1:0]     acc_valid_i,
  input  logic [N*W-1:0]   acc_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [W-1:0]     out_data_o,
  output logic [LOG_N-1:0] out_row_o,
  output logic [LOG_N-1:0] out_col_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CW = LOG_N + 1;
  localparam int PW = 2 * LOG_N + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(N * N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_r;
  logic [W-1:0]        buf_r [N][N];
  logic [CW-1:0]       cnt_r [N];
  logic [PW-1:0]       ptr_r;
  logic                out_valid_r;
  logic [W-1:0]        out_data_r;
  logic [LOG_N-1:0]    out_row_r;
  logic [LOG_N-1:0]    out_col_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  logic [N-1:0]        cap_s;
  logic [N-1:0]        full_s;
  logic                ovf_s;
  logic [PW-1:0]       ptr_nxt_s;
  logic [LOG_N-1:0]    row_nxt_s;
  logic [LOG_N-1:0]    col_nxt_s;
  logic [W-1:0]        first_s;

  // Per-column capture qualification and "tile complete after this edge" detection.
  always_comb begin
    cap_s  = '0;
    full_s = '0;
    for (int c = 0; c < N; c++) begin
      if (acc_valid_i[c] && (cnt_r[c] < CNT_FULL)) begin
        cap_s[c] = 1'b1;
      end else begin
        cap_s[c] = 1'b0;
      end
      if ((cnt_r[c] == CNT_FULL) || (cap_s[c] && (cnt_r[c] == CNT_LAST))) begin
        full_s[c] = 1'b1;
      end else begin
        full_s[c] = 1'b0;
      end
    end
  end

  // Drain pointer arithmetic and the first element, bypassed when it lands on the exit edge.
  always_comb begin
    ovf_s     = |(acc_valid_i & ~cap_s);
    ptr_nxt_s = ptr_r + PW'(1);
    row_nxt_s = ptr_nxt_s[2*LOG_N-1:LOG_N];
    col_nxt_s = ptr_nxt_s[LOG_N-1:0];
    if (cap_s[0] && (cnt_r[0] == CW'(0))) begin
      first_s = acc_data_i[W-1:0];
    end else begin
      first_s = buf_r[0][0];
    end
  end

  // Tile buffer: row is the column's arrival order; deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (state_r == COLLECT) begin
      for (int c = 0; c < N; c++) begin
        if (cap_s[c]) begin
          buf_r[cnt_r[c][LOG_N-1:0]][c] <= acc_data_i[c*W +: W];
        end
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      for (int c = 0; c < N; c++) begin
        cnt_r[c] <= '0;
      end
      ptr_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_row_r   <= '0;
      out_col_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_i) begin
            state_r <= COLLECT;
            for (int c = 0; c < N; c++) begin
              cnt_r[c] <= '0;
            end
            ptr_r  <= '0;
            err_r  <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b1;
          end else if ((state_r == DONE) && (|acc_valid_i)) begin
            err_r <= 1'b1;
          end
        end
        COLLECT: begin
          for (int c = 0; c < N; c++) begin
            if (cap_s[c]) begin
              cnt_r[c] <= cnt_r[c] + CW'(1);
            end
          end
          if (ovf_s) begin
            err_r <= 1'b1;
          end
          if (&full_s) begin
            state_r     <= DRAIN;
            out_valid_r <= 1'b1;
            out_data_r  <= first_s;
            out_row_r   <= '0;
            out_col_r   <= '0;
          end
        end
        DRAIN: begin
          if (|acc_valid_i) begin
            err_r <= 1'b1;
          end
          if (out_valid_r && out_ready_i) begin
            ptr_r <= ptr_nxt_s;
            if (ptr_r == PTR_LAST) begin
              state_r     <= DONE;
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              out_data_r <= buf_r[row_nxt_s][col_nxt_s];
              out_row_r  <= row_nxt_s;
              out_col_r  <= col_nxt_s;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;
  assign out_row_o   = out_row_r;
  assign out_col_o   = out_col_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign err_o       = err_r;

endmodule
